// File: rtl/sparse_stream_encoder_pkg.sv
// Shared constants, packet layout and helpers for the sparse stream encoder.
// Lane geometry matches the PPU output count and OARAM index width.
package sparse_stream_encoder_pkg;

  localparam int N       = 4;
  localparam int IDX_W   = 4;
  localparam int CH_W    = 6;
  localparam int DATA_W  = 16;
  localparam int RUN_MAX = (1 << IDX_W) - 1;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [N-1:0][DATA_W-1:0] data;
    logic [N-1:0][IDX_W-1:0]  indices;
    logic [N-1:0]             mask;
    logic [CH_W-1:0]          channel;
    logic                     last;
  } sparse_pkt_t;

  // Negative values count as zero when the ReLU is folded into the encoder.
  function automatic logic is_zero(input logic [DATA_W-1:0] v, input logic relu);
    return (v == '0) || (relu && v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/sparse_stream_encoder_if.sv
// Dense input stream and sparse packet output of the encoder, plus its FSM state.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface sparse_stream_encoder_if;
  import sparse_stream_encoder_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [CH_W-1:0]         in_channel;
  logic                    in_last;

  logic                    out_valid;
  logic                    out_ready;
  logic [N*DATA_W-1:0]     out_data;
  logic [N*IDX_W-1:0]      out_indices;
  logic [N-1:0]            out_mask;
  logic [CH_W-1:0]         out_channel;
  logic                    out_last;
  logic [15:0]             nnz_count;
  enc_state_t              dbg_state;

  modport slave (
    input  in_valid, in_data, in_channel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_indices, out_mask,
           out_channel, out_last, nnz_count, dbg_state
  );

  modport master (
    output in_valid, in_data, in_channel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_indices, out_mask,
           out_channel, out_last, nnz_count, dbg_state
  );
endinterface

// File: rtl/sparse_stream_encoder_zrc.sv
// Zero-run counter: tracks zeros since the last emitted entry and decides when an entry is written.
// A full run forces a (0, RUN_MAX) filler entry so the index never overflows.
module zero_run_counter
  import sparse_stream_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic             accept,
  input  logic             clear,
  output logic             emit,
  output logic [IDX_W-1:0] run_idx,
  output logic             overflow
);

  logic [IDX_W-1:0] run;
  logic             at_max;

  assign at_max   = (run == IDX_W'(RUN_MAX));
  assign emit     = accept && (!zero || at_max);
  assign overflow = accept && zero && at_max;
  assign run_idx  = run;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run <= '0;
    end else if (accept) begin
      run <= emit ? '0 : run + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sparse_stream_encoder.sv
// Packs nonzero dense elements with their zero-run indices into N-lane packets for the OARAM.
// FILL collects lanes; SEND holds the packet until the consumer takes it (one bubble per packet).
module sparse_stream_encoder
  import sparse_stream_encoder_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  sparse_stream_encoder_if.slave bus
);

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  enc_state_t        state;
  sparse_pkt_t       pkt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [LANE_W-1:0] lane;
  logic [15:0]       nnz;
  logic              chan_open;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              accept;
  logic              zero;
  logic              emit;
  logic              overflow;
  logic              run_clear;
  logic [IDX_W-1:0]  run_idx;

  assign accept    = in_ready_q && bus.in_valid;
  assign zero      = is_zero(bus.in_data, RELU_EN);
  assign count_nxt = count + CNT_W'(emit);
  assign lane      = count[LANE_W-1:0];
  // The run survives packet boundaries inside a channel and only resets once the channel closes.
  assign run_clear = (state == SEND) && bus.out_ready && pkt.last;

  zero_run_counter u_zrc (
    .clk      (clk),
    .rst      (rst),
    .zero     (zero),
    .accept   (accept),
    .clear    (run_clear),
    .emit     (emit),
    .run_idx  (run_idx),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      pkt         <= '0;
      count       <= '0;
      nnz         <= '0;
      chan_open   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (!chan_open) begin
              pkt.channel <= bus.in_channel;
              chan_open   <= 1'b1;
            end
            if (emit) begin
              pkt.data[lane]    <= overflow ? '0 : bus.in_data;
              pkt.indices[lane] <= run_idx;
              pkt.mask[lane]    <= 1'b1;
              nnz               <= nnz + 16'd1;
            end
            count <= count_nxt;
            if (count_nxt == CNT_W'(N) || bus.in_last) begin
              state       <= SEND;
              pkt.last    <= bus.in_last;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            state       <= FILL;
            pkt.data    <= '0;
            pkt.indices <= '0;
            pkt.mask    <= '0;
            pkt.last    <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            if (pkt.last) begin
              nnz       <= '0;
              chan_open <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = pkt.data;
  assign bus.out_indices = pkt.indices;
  assign bus.out_mask    = pkt.mask;
  assign bus.out_channel = pkt.channel;
  assign bus.out_last    = pkt.last;
  assign bus.nnz_count   = nnz;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_sparse_stream_encoder.sv
// Bench for sparse_stream_encoder: directed scenarios plus randomized channels checked
// against a list-based model; one DUT with ReLU folding and one without.
module tb_sparse_stream_encoder;
  import sparse_stream_encoder_pkg::*;

  localparam int EXP_W = $bits(sparse_pkt_t) + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic              sel;        // 0: ReLU DUT, 1: plain DUT
  logic              in_valid;
  logic [15:0]       in_data;
  logic [CH_W-1:0]   in_channel;
  logic              in_last;
  logic              out_ready;

  sparse_stream_encoder_if if_r ();
  sparse_stream_encoder_if if_n ();

  assign if_r.in_valid   = in_valid && !sel;
  assign if_r.in_data    = in_data;
  assign if_r.in_channel = in_channel;
  assign if_r.in_last    = in_last;
  assign if_r.out_ready  = sel ? 1'b1 : out_ready;
  assign if_n.in_valid   = in_valid && sel;
  assign if_n.in_data    = in_data;
  assign if_n.in_channel = in_channel;
  assign if_n.in_last    = in_last;
  assign if_n.out_ready  = sel ? out_ready : 1'b1;

  sparse_stream_encoder #(.RELU_EN(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(if_r));
  sparse_stream_encoder #(.RELU_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  logic                o_valid, o_in_ready, o_last;
  logic [N*16-1:0]     o_data;
  logic [N*IDX_W-1:0]  o_idx;
  logic [N-1:0]        o_mask;
  logic [CH_W-1:0]     o_ch;
  logic [15:0]         o_nnz;

  assign o_valid    = sel ? if_n.out_valid   : if_r.out_valid;
  assign o_in_ready = sel ? if_n.in_ready    : if_r.in_ready;
  assign o_last     = sel ? if_n.out_last    : if_r.out_last;
  assign o_data     = sel ? if_n.out_data    : if_r.out_data;
  assign o_idx      = sel ? if_n.out_indices : if_r.out_indices;
  assign o_mask     = sel ? if_n.out_mask    : if_r.out_mask;
  assign o_ch       = sel ? if_n.out_channel : if_r.out_channel;
  assign o_nnz      = sel ? if_n.nnz_count   : if_r.nnz_count;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      stim_q[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  bit               drv_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [N*16-1:0] d, input logic [N*IDX_W-1:0] ix,
                          input logic [N-1:0] m, input logic [CH_W-1:0] ch,
                          input logic l, input logic [15:0] nz);
    sparse_pkt_t p;
    p.data = d; p.indices = ix; p.mask = m; p.channel = ch; p.last = l;
    exp_q.push_back({p, nz});
  endtask

  // Reference: walk the channel's element list and cut packets by the zero-run rules.
  task automatic build_expect(input bit relu, input logic [CH_W-1:0] ch);
    sparse_pkt_t p;
    int run = 0, cnt = 0, nnz = 0;
    bit z, last;
    p = '0;
    p.channel = ch;
    for (int i = 0; i < stim_q.size(); i++) begin
      last = (i == stim_q.size() - 1);
      z = (stim_q[i] == 16'd0) || (relu && stim_q[i] >= 16'h8000);
      if (!z || run == RUN_MAX) begin
        p.data[cnt]    = z ? 16'd0 : stim_q[i];
        p.indices[cnt] = IDX_W'(run);
        p.mask[cnt]    = 1'b1;
        cnt++; nnz++; run = 0;
      end else begin
        run++;
      end
      if (cnt == N || last) begin
        p.last = last;
        exp_q.push_back({p, 16'(nnz)});
        p.data = '0; p.indices = '0; p.mask = '0; p.last = 1'b0;
        cnt = 0;
      end
    end
  endtask

  // Every cycle a packet is shown it must equal the head of the queue, so a stall checks stability.
  logic [EXP_W-1:0] mon_e;
  sparse_pkt_t      mon_p;
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt", {o_data, o_mask}, 0);
      end else begin
        mon_e = exp_q[0];
        mon_p = mon_e[EXP_W-1:16];
        chk("out_data", o_data, mon_p.data);
        chk("out_indices", o_idx, mon_p.indices);
        chk("out_mask", o_mask, mon_p.mask);
        chk("out_channel", o_ch, mon_p.channel);
        chk("out_last", o_last, mon_p.last);
        chk("nnz_count", o_nnz, mon_e[15:0]);
        chk("in_ready_in_send", o_in_ready, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic drive_elem(input logic [15:0] d, input logic l);
    int k = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!o_in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 200) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drive_seq(input logic [CH_W-1:0] ch, input bit close);
    in_channel = ch;
    for (int i = 0; i < stim_q.size(); i++)
      drive_elem(stim_q[i], close && (i == stim_q.size() - 1));
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset();
    chk("rst_in_ready_r", if_r.in_ready, 1);
    chk("rst_out_valid_r", if_r.out_valid, 0);
    chk("rst_outputs_r", {if_r.out_data, if_r.out_indices, if_r.out_mask,
                          if_r.out_channel, if_r.out_last}, 0);
    chk("rst_nnz_r", if_r.nnz_count, 0);
    chk("rst_state_r", if_r.dbg_state, FILL);
    chk("rst_in_ready_n", if_n.in_ready, 1);
    chk("rst_out_valid_n", if_n.out_valid, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    sel = 1'b0; in_valid = 1'b0; in_data = '0; in_channel = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset();

    // 1: mixed runs, four entries closing exactly on the last element
    stim_q = '{16'd0, 16'd0, 16'd5, 16'd0, 16'd7, 16'd9, 16'd0, 16'd0, 16'd0, 16'd3};
    push_exp({16'd3, 16'd9, 16'd7, 16'd5}, {4'd3, 4'd0, 4'd1, 4'd2}, 4'b1111, 6'd2, 1'b1, 16'd4);
    drive_seq(6'd2, 1'b1);
    wait_drain();

    // 2: 20 zeros force one filler entry before the value
    stim_q.delete();
    repeat (20) stim_q.push_back(16'd0);
    stim_q.push_back(16'd8);
    push_exp({16'd0, 16'd0, 16'd8, 16'd0}, {4'd0, 4'd0, 4'd4, 4'd15}, 4'b0011, 6'd3, 1'b1, 16'd2);
    drive_seq(6'd3, 1'b1);
    wait_drain();

    // 3: back-pressure holds the first packet for 5 cycles
    stim_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    push_exp({16'd4, 16'd3, 16'd2, 16'd1}, 16'h0000, 4'b1111, 6'd7, 1'b0, 16'd4);
    push_exp({16'd0, 16'd0, 16'd6, 16'd5}, 16'h0000, 4'b0011, 6'd7, 1'b1, 16'd6);
    out_ready = 1'b0;
    fork
      drive_seq(6'd7, 1'b1);
      begin
        int k = 0;
        while (!o_valid && k < 100) begin @(posedge clk); #1; k++; end
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // 4: negative input with ReLU folding, then the same stream without it
    stim_q = '{16'hFFFD, 16'd0, 16'd4};
    push_exp({16'd0, 16'd0, 16'd0, 16'd4}, {4'd0, 4'd0, 4'd0, 4'd2}, 4'b0001, 6'd9, 1'b1, 16'd1);
    drive_seq(6'd9, 1'b1);
    wait_drain();
    sel = 1'b1;
    push_exp({16'd0, 16'd0, 16'd4, 16'hFFFD}, {4'd0, 4'd0, 4'd1, 4'd0}, 4'b0011, 6'd9, 1'b1, 16'd2);
    drive_seq(6'd9, 1'b1);
    wait_drain();
    sel = 1'b0;

    // 5: all-zero channel still closes with an empty packet
    stim_q = '{16'd0, 16'd0, 16'd0};
    push_exp('0, '0, 4'b0000, 6'd1, 1'b1, 16'd0);
    drive_seq(6'd1, 1'b1);
    wait_drain();

    // 6: reset discards a partial packet; channel is re-latched afterwards
    stim_q = '{16'd7, 16'd0, 16'd9};
    drive_seq(6'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset();
    stim_q = '{16'd1};
    push_exp({16'd0, 16'd0, 16'd0, 16'd1}, '0, 4'b0001, 6'd5, 1'b1, 16'd1);
    drive_seq(6'd5, 1'b1);
    wait_drain();

    // random channels on both DUTs with random back-pressure
    for (int r = 0; r < 12; r++) begin
      logic [CH_W-1:0] ch;
      int len, zp;
      sel = r[0];
      ch  = CH_W'($urandom_range(0, (1 << CH_W) - 1));
      len = $urandom_range(1, 40);
      zp  = $urandom_range(30, 95);
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) < zp)       stim_q.push_back(16'd0);
        else if ($urandom_range(0, 3) == 0)   stim_q.push_back(16'h8000 | 16'($urandom_range(0, 16'h7FFF)));
        else                                  stim_q.push_back(16'($urandom_range(1, 16'h7FFF)));
      end
      build_expect(!sel, ch);
      drv_done = 1'b0;
      fork
        begin drive_seq(ch, 1'b1); drv_done = 1'b1; end
        begin
          while (!drv_done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
      join
      wait_drain();
    end
    sel = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
